// File: rtl/inst_sram_responder.sv
// inst_sram_responder: single-outstanding instruction fetch responder with address classification and bus timeout.
// Define INST_SRAM_TLB_EN to translate mapped addresses through the external TLB lookup.
module inst_sram_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] inst_sram_addr,
  input  logic        inst_sram_readen,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_valid,
  output logic        inst_sram_addressError,
  output logic        inst_sram_tlb_miss,
  output logic        inst_sram_tlb_invalid,
  output logic        inst_sram_tlb_ready,
  output logic [19:0] tlb_vpn,
  input  logic        tlb_hit,
  input  logic        tlb_v,
  input  logic [19:0] tlb_pfn,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t      r_state;
  logic [31:0] r_rdata, r_mem_addr;
  logic [15:0] r_cnt;
  logic        r_valid, r_aerr, r_miss, r_inv, r_ready, r_mem_req;
  logic        w_misalign, w_miss, w_inv, w_err;
  logic [31:0] w_pa;
  assign w_misalign = |inst_sram_addr[1:0];
`ifdef INST_SRAM_TLB_EN
  logic w_kseg;
  assign w_kseg  = inst_sram_addr[31:30] == 2'b10;
  assign tlb_vpn = inst_sram_addr[31:12];
  assign w_miss  = !w_kseg && !tlb_hit;
  assign w_inv   = !w_kseg && tlb_hit && !tlb_v;
  assign w_pa    = w_kseg ? {3'b000, inst_sram_addr[28:0]} : {tlb_pfn, inst_sram_addr[11:0]};
`else
  logic w_unused;
  assign w_unused = &{1'b0, tlb_hit, tlb_v, tlb_pfn, inst_sram_addr[31:29]};
  assign tlb_vpn  = '0;
  assign w_miss   = 1'b0;
  assign w_inv    = 1'b0;
  assign w_pa     = {3'b000, inst_sram_addr[28:0]};
`endif
  assign w_err = w_misalign | w_miss | w_inv;
  // Response flags default low each cycle so RESP lasts exactly one cycle unless re-entered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_rdata    <= '0;
      r_mem_addr <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_aerr     <= 1'b0;
      r_miss     <= 1'b0;
      r_inv      <= 1'b0;
      r_ready    <= 1'b0;
      r_mem_req  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_aerr  <= 1'b0;
      r_miss  <= 1'b0;
      r_inv   <= 1'b0;
      r_ready <= 1'b0;
      if (r_state == FETCH) begin
        if (mem_ack) begin
          r_rdata   <= mem_rdata;
          r_valid   <= 1'b1;
          r_ready   <= 1'b1;
          r_mem_req <= 1'b0;
          r_state   <= RESP;
        end else if (r_cnt == LP_LAST) begin
          r_aerr    <= 1'b1;
          r_ready   <= 1'b1;
          r_mem_req <= 1'b0;
          r_state   <= RESP;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end else if (inst_sram_readen) begin
        if (w_err) begin
          r_aerr  <= w_misalign;
          r_miss  <= !w_misalign && w_miss;
          r_inv   <= !w_misalign && w_inv;
          r_ready <= 1'b1;
          r_state <= RESP;
        end else begin
          r_mem_req  <= 1'b1;
          r_mem_addr <= w_pa;
          r_cnt      <= '0;
          r_state    <= FETCH;
        end
      end else begin
        r_state <= IDLE;
      end
    end
  end
  assign inst_sram_rdata        = r_rdata;
  assign inst_sram_valid        = r_valid;
  assign inst_sram_addressError = r_aerr;
  assign inst_sram_tlb_miss     = r_miss;
  assign inst_sram_tlb_invalid  = r_inv;
  assign inst_sram_tlb_ready    = r_ready;
  assign mem_req                = r_mem_req;
  assign mem_addr               = r_mem_addr;
endmodule

// File: tb/tb_inst_sram_responder.sv
// tb_inst_sram_responder: table-driven fetch vectors with a response scoreboard and hand-written corner sequences.
module tb_inst_sram_responder;
  localparam int TO = 4;
  logic        clk = 1'b0, resetn = 1'b0;
  logic [31:0] addr = '0, rdata, mem_addr, mem_rdata = '0;
  logic        readen = 1'b0, valid, aerr, miss, inv, ready, mem_req, mem_ack = 1'b0;
  logic        hit = 1'b0, v = 1'b0;
  logic [19:0] pfn = '0, vpn;
  int          checks = 0, errors = 0;
  logic [31:0] last_rdata = '0;

  inst_sram_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .inst_sram_addr(addr), .inst_sram_readen(readen),
    .inst_sram_rdata(rdata), .inst_sram_valid(valid), .inst_sram_addressError(aerr),
    .inst_sram_tlb_miss(miss), .inst_sram_tlb_invalid(inv), .inst_sram_tlb_ready(ready),
    .tlb_vpn(vpn), .tlb_hit(hit), .tlb_v(v), .tlb_pfn(pfn),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] FV = 4'b1000, FA = 4'b0100, FM = 4'b0010, FI = 4'b0001;
  typedef struct packed {
    logic [31:0] addr;
    logic        hit, v;
    logic [19:0] pfn;
    logic [3:0]  ack_at;
    logic [31:0] rdata;
    logic        fetch;
    logic [3:0]  flags;
    logic [31:0] pa;
  } vec_t;
  typedef struct packed {
    logic [3:0]  flags;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard side: every tlb_ready pops one expectation; otherwise all flags must be low.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {28'd0, valid, aerr, miss, inv}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_flags", {28'd0, valid, aerr, miss, inv}, {28'd0, e.flags});
        if (e.flags == FV) chk("resp_rdata", rdata, e.rdata);
      end
    end else begin
      chk("idle_flags", {28'd0, valid, aerr, miss, inv}, 32'd0);
    end
  end

  task automatic run_vec(input vec_t t);
    int cycles;
    @(negedge clk);
    addr = t.addr; hit = t.hit; v = t.v; pfn = t.pfn; readen = 1'b1;
    sb.push_back('{flags: t.flags, rdata: t.rdata});
    #1;
`ifdef INST_SRAM_TLB_EN
    chk("tlb_vpn", {12'd0, vpn}, {12'd0, t.addr[31:12]});
`else
    chk("tlb_vpn", {12'd0, vpn}, 32'd0);
`endif
    @(negedge clk);
    readen = 1'b0;
    cycles = 0;
    if (t.fetch) begin
      while (mem_req === 1'b1 && cycles < 100) begin
        if (cycles == 0) chk("mem_addr", mem_addr, t.pa);
        if (cycles + 1 == int'(t.ack_at)) begin
          mem_ack = 1'b1; mem_rdata = t.rdata;
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        cycles++;
      end
      chk("fetch_cycles", cycles, (t.ack_at == 0) ? TO : int'(t.ack_at));
    end else begin
      chk("no_mem_req", {31'd0, mem_req}, 32'd0);
    end
    chk("resp_ready", {31'd0, ready}, 32'd1);
    if (t.flags == FV) last_rdata = t.rdata;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{32'hBFC0_0000, 1'b0, 1'b0, 20'h0, 4'd3, 32'h3C1D_8000, 1'b1, FV, 32'h1FC0_0000};
    vecs[1] = '{32'h0040_0002, 1'b0, 1'b0, 20'h0, 4'd0, 32'h0, 1'b0, FA, 32'h0};
`ifdef INST_SRAM_TLB_EN
    vecs[2] = '{32'h0040_0000, 1'b0, 1'b0, 20'h0, 4'd0, 32'h0, 1'b0, FM, 32'h0};
    vecs[3] = '{32'h0040_0000, 1'b1, 1'b0, 20'h0, 4'd0, 32'h0, 1'b0, FI, 32'h0};
    vecs[4] = '{32'h0040_0000, 1'b1, 1'b1, 20'h01234, 4'd1, 32'hCAFE_F00D, 1'b1, FV, 32'h0123_4000};
    vecs[7] = '{32'hC000_0010, 1'b1, 1'b1, 20'hABCDE, 4'd2, 32'h55AA_55AA, 1'b1, FV, 32'hABCD_E010};
`else
    vecs[2] = '{32'h0040_0000, 1'b0, 1'b0, 20'h0, 4'd1, 32'h0BAD_0001, 1'b1, FV, 32'h0040_0000};
    vecs[3] = '{32'h0040_0000, 1'b1, 1'b0, 20'h0, 4'd1, 32'h0BAD_0002, 1'b1, FV, 32'h0040_0000};
    vecs[4] = '{32'h0040_0000, 1'b1, 1'b1, 20'h01234, 4'd1, 32'hCAFE_F00D, 1'b1, FV, 32'h0040_0000};
    vecs[7] = '{32'hC000_0010, 1'b1, 1'b1, 20'hABCDE, 4'd2, 32'h55AA_55AA, 1'b1, FV, 32'h0000_0010};
`endif
    vecs[5] = '{32'hA000_0004, 1'b0, 1'b0, 20'h0, 4'd2, 32'hDEAD_BEEF, 1'b1, FV, 32'h0000_0004};
    vecs[6] = '{32'h7FFF_FFFF, 1'b0, 1'b0, 20'h0, 4'd0, 32'h0, 1'b0, FA, 32'h0};
    vecs[8] = '{32'h8000_1000, 1'b0, 1'b0, 20'h0, 4'd0, 32'h0, 1'b1, FA, 32'h0000_1000};

    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Late ack after the timeout must neither respond nor disturb rdata.
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_rdata", rdata, last_rdata);
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);

    // Back-to-back: new request presented during RESP enters FETCH with no IDLE gap.
    addr = 32'h0000_0002; readen = 1'b1;
    sb.push_back('{flags: FA, rdata: 32'h0});
    @(negedge clk);
    addr = 32'h8000_0100;
    sb.push_back('{flags: FV, rdata: 32'h1111_2222});
    @(negedge clk);
    readen = 1'b0;
    chk("b2b_mem_req", {31'd0, mem_req}, 32'd1);
    chk("b2b_mem_addr", mem_addr, 32'h0000_0100);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);

    // Reset mid-FETCH: mem_req drops at once and no response follows.
    addr = 32'h8000_0200; readen = 1'b1;
    @(negedge clk);
    readen = 1'b0;
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_drop_req", {31'd0, mem_req}, 32'd0);
    chk("rst_clr_rdata", rdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_req", {31'd0, mem_req}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
